// File: rtl/addsub_checker.sv
// addsub_checker: self-running checker for a 16-bit adder-subtractor.
//
// A Galois LFSR (taps 16'hB400) generates operand pairs. For each vector the
// checker drives the operands and mode, waits SETTLE_CYCLES, then compares
// the DUT results against a built-in golden model. Mismatches are counted and
// the first failing vector is captured.
//
// Per-vector timing: DRIVE (1) + SETTLE (SETTLE_CYCLES) + CHECK (1).
//
// Parameters
//   NUM_VECTORS   vectors per run (1..65535)
//   SETTLE_CYCLES wait cycles before sampling (1..255)
//   SEED          nonzero LFSR start value
//
// Ports
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   start               run request (honoured in IDLE/DONE only)
//   dut_input1/2        operands to the DUT under test
//   dut_S, dut_I        mode to the DUT: S=1 signed, I=1 subtract
//   dut_sum, dut_outc, dut_borrow, dut_overflow  DUT results
//   busy, done, pass    run status
//   vec_count           vectors checked in this run
//   fail_count          mismatches seen (saturating)
//   err_input1/2        operands of the first failing vector
//   err_mode            {S,I} of the first failing vector
//
// Configuration macro
//   ADDSUB_CHECKER_STOP_ON_FAIL_EN  defined: the first mismatch ends the run;
//                                   undefined: always run all vectors.
//
// State | Meaning
// IDLE   | waiting for start after reset
// DRIVE  | step LFSR twice, register operands and mode
// SETTLE | hold operands for SETTLE_CYCLES cycles
// CHECK  | compare DUT results with golden, update counters
// DONE   | run finished, status held until next start

module addsub_checker #(
  parameter int          NUM_VECTORS   = 256,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [15:0] dut_input1,
  output logic [15:0] dut_input2,
  output logic        dut_S,
  output logic        dut_I,
  input  logic [15:0] dut_sum,
  input  logic        dut_outc,
  input  logic        dut_borrow,
  input  logic        dut_overflow,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] vec_count,
  output logic [15:0] fail_count,
  output logic [15:0] err_input1,
  output logic [15:0] err_input2,
  output logic [1:0]  err_mode
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
  localparam logic [7:0]  SETTLE_TOP = 8'(SETTLE_CYCLES - 1);

`ifdef ADDSUB_CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] in1_q, in1_d;
  logic [15:0] in2_q, in2_d;
  logic        s_q, s_d;
  logic        i_q, i_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] vec_q, vec_d;
  logic [15:0] fail_q, fail_d;
  logic [15:0] err_in1_q, err_in1_d;
  logic [15:0] err_in2_q, err_in2_d;
  logic [1:0]  err_mode_q, err_mode_d;
  logic        pass_q, pass_d;

  // Golden model, evaluated on the held operands.
  logic [15:0] op_b;
  logic [16:0] gold;
  logic        gold_borrow;
  logic        gold_ovf;
  logic        mismatch;
  logic [15:0] step1;
  logic [15:0] step2;

  always_comb begin
    op_b        = i_q ? ~in2_q : in2_q;
    gold        = {1'b0, in1_q} + {1'b0, op_b} + {16'd0, i_q};
    gold_borrow = (in1_q < in2_q);
    // Signed overflow: operands (after inversion for subtract) share a sign
    // that differs from the result sign.
    gold_ovf    = (in1_q[15] == op_b[15]) && (gold[15] != in1_q[15]);
    mismatch    = (dut_sum != gold[15:0])
               || (dut_outc != gold[16])
               || (i_q && (dut_borrow != gold_borrow))
               || (s_q && (dut_overflow != gold_ovf));
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    s_d        = s_q;
    i_d        = i_q;
    settle_d   = settle_q;
    vec_d      = vec_q;
    fail_d     = fail_q;
    err_in1_d  = err_in1_q;
    err_in2_d  = err_in2_q;
    err_mode_d = err_mode_q;
    pass_d     = pass_q;
    step1      = lfsr_step(lfsr_q);
    step2      = lfsr_step(step1);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = DRIVE;
          lfsr_d     = SEED;
          vec_d      = 16'd0;
          fail_d     = 16'd0;
          err_in1_d  = 16'd0;
          err_in2_d  = 16'd0;
          err_mode_d = 2'd0;
          pass_d     = 1'b0;
        end
      end
      DRIVE: begin
        in1_d      = step1;
        in2_d      = step2;
        lfsr_d     = step2;
        {s_d, i_d} = vec_q[1:0];
        settle_d   = SETTLE_TOP;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (settle_q == 8'd0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      CHECK: begin
        vec_d = vec_q + 16'd1;
        if (mismatch) begin
          if (fail_q != 16'hFFFF) begin
            fail_d = fail_q + 16'd1;
          end
          if (fail_q == 16'd0) begin
            err_in1_d  = in1_q;
            err_in2_d  = in2_q;
            err_mode_d = {s_q, i_q};
          end
        end
        if ((vec_q == LAST_VEC) || (STOP_ON_FAIL && mismatch)) begin
          state_d = DONE;
          pass_d  = (fail_d == 16'd0);
        end else begin
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      in1_q      <= 16'd0;
      in2_q      <= 16'd0;
      s_q        <= 1'b0;
      i_q        <= 1'b0;
      settle_q   <= 8'd0;
      vec_q      <= 16'd0;
      fail_q     <= 16'd0;
      err_in1_q  <= 16'd0;
      err_in2_q  <= 16'd0;
      err_mode_q <= 2'd0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      s_q        <= s_d;
      i_q        <= i_d;
      settle_q   <= settle_d;
      vec_q      <= vec_d;
      fail_q     <= fail_d;
      err_in1_q  <= err_in1_d;
      err_in2_q  <= err_in2_d;
      err_mode_q <= err_mode_d;
      pass_q     <= pass_d;
    end
  end

  assign dut_input1 = in1_q;
  assign dut_input2 = in2_q;
  assign dut_S      = s_q;
  assign dut_I      = i_q;
  assign busy       = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign vec_count  = vec_q;
  assign fail_count = fail_q;
  assign err_input1 = err_in1_q;
  assign err_input2 = err_in2_q;
  assign err_mode   = err_mode_q;

endmodule

// File: tb/tb_addsub_checker.sv
// Testbench for addsub_checker: a behavioural adder-subtractor (with an
// optional sum[0] stuck-at-0 fault) sits behind the checker. Expected operand
// vectors and end-of-run results are queued when each run is issued; a
// monitor pops and compares them as the checker presents operands and when
// done rises.
module tb_addsub_checker;

  localparam int NV  = 8;
  localparam int SC  = 2;
  localparam int PER = SC + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dut_input1, dut_input2;
  logic        dut_S, dut_I;
  logic [15:0] dut_sum;
  logic        dut_outc, dut_borrow, dut_overflow;
  logic        busy, done, pass;
  logic [15:0] vec_count, fail_count, err_input1, err_input2;
  logic [1:0]  err_mode;
  bit          fault = 1'b0;
  logic [18:0] model_r;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  m;
  } vec_t;

  typedef struct {
    int          vc;
    int          fc;
    int          cycles;
    bit          pass;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [1:0]  em;
  } res_t;

  vec_t opq[$];
  res_t resq[$];

  addsub_checker #(.NUM_VECTORS(NV), .SETTLE_CYCLES(SC), .SEED(16'hACE1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .dut_input1(dut_input1), .dut_input2(dut_input2),
    .dut_S(dut_S), .dut_I(dut_I),
    .dut_sum(dut_sum), .dut_outc(dut_outc),
    .dut_borrow(dut_borrow), .dut_overflow(dut_overflow),
    .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .fail_count(fail_count),
    .err_input1(err_input1), .err_input2(err_input2), .err_mode(err_mode)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Returns {overflow, borrow, outc, sum} using integer arithmetic.
  function automatic logic [18:0] ref_addsub(input logic [15:0] a, input logic [15:0] b,
                                             input logic i);
    int   sa, sb, sr;
    logic outc, bo, ov;
    logic [15:0] sum;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (i) begin
      sum  = a - b;
      outc = (a >= b);
      bo   = (a < b);
      sr   = sa - sb;
    end else begin
      sum  = a + b;
      outc = ({16'd0, a} + {16'd0, b}) > 32'hFFFF;
      bo   = 1'b0;
      sr   = sa + sb;
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, bo, outc, sum};
  endfunction

  always_comb begin
    model_r      = ref_addsub(dut_input1, dut_input2, dut_I);
    dut_sum      = model_r[15:0];
    if (fault) dut_sum[0] = 1'b0;
    dut_outc     = model_r[16];
    dut_borrow   = model_r[17];
    dut_overflow = model_r[18];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Queue the operand vectors and end-of-run result for one run.
  task automatic plan_run(input bit flt);
    logic [15:0] x, a, b;
    logic [18:0] r;
    int   fc, nv;
    bit   stop;
    vec_t v;
    res_t e;
    x = 16'hACE1; fc = 0; nv = 0; stop = 1'b0;
    for (int k = 0; k < NV && !stop; k++) begin
      a = lfsr_step(x);
      b = lfsr_step(a);
      x = b;
      v.a = a; v.b = b; v.m = 2'(k);
      opq.push_back(v);
      nv++;
      r = ref_addsub(a, b, v.m[0]);
      if (flt && r[0]) begin
        fc++;
`ifdef ADDSUB_CHECKER_STOP_ON_FAIL_EN
        stop = 1'b1;
`endif
      end
    end
    e.vc = nv; e.fc = fc; e.cycles = nv * PER; e.pass = (fc == 0);
    // Hand-computed: vectors 0..2 give even sums, vector 3 (ED89 - C2C4 = 2AC5,
    // mode {S,I}=11) is the first with sum[0]=1.
    if (flt) begin
      e.ea = 16'hED89; e.eb = 16'hC2C4; e.em = 2'b11;
    end else begin
      e.ea = 16'h0; e.eb = 16'h0; e.em = 2'b00;
    end
    resq.push_back(e);
  endtask

  // Monitor: operands are visible on the first SETTLE cycle of each vector
  // (busy cycle 2, 6, 10, ...); results are checked when done rises.
  initial begin
    int   bcnt;
    logic busy_p, done_p;
    vec_t v;
    res_t e;
    bcnt = 0; busy_p = 1'b0; done_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bcnt = 0; busy_p = 1'b0; done_p = 1'b0;
      end else begin
        if (busy && !busy_p) bcnt = 0;
        if (busy) begin
          bcnt++;
          if (bcnt % PER == 2) begin
            if (opq.size() == 0) begin
              chk("opq_underflow", 32'd1, 32'd0);
            end else begin
              v = opq.pop_front();
              chk("vec_input1", {16'd0, dut_input1}, {16'd0, v.a});
              chk("vec_input2", {16'd0, dut_input2}, {16'd0, v.b});
              chk("vec_mode", {30'd0, dut_S, dut_I}, {30'd0, v.m});
            end
          end
        end
        if (done && !done_p) begin
          if (resq.size() == 0) begin
            chk("resq_underflow", 32'd1, 32'd0);
          end else begin
            e = resq.pop_front();
            chk("run_vec_count", {16'd0, vec_count}, 32'(e.vc));
            chk("run_fail_count", {16'd0, fail_count}, 32'(e.fc));
            chk("run_pass", {31'd0, pass}, {31'd0, e.pass});
            chk("run_busy_cycles", 32'(bcnt), 32'(e.cycles));
            chk("run_err_input1", {16'd0, err_input1}, {16'd0, e.ea});
            chk("run_err_input2", {16'd0, err_input2}, {16'd0, e.eb});
            chk("run_err_mode", {30'd0, err_mode}, {30'd0, e.em});
          end
        end
        busy_p = busy;
        done_p = done;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      bad++;
      total++;
      $display("FAIL %s: timeout waiting for done, got 0 expected 1", nm);
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in1"}, {16'd0, dut_input1}, 32'd0);
    chk({nm, "_in2"}, {16'd0, dut_input2}, 32'd0);
    chk({nm, "_mode"}, {30'd0, dut_S, dut_I}, 32'd0);
    chk({nm, "_status"}, {29'd0, busy, done, pass}, 32'd0);
    chk({nm, "_vec"}, {16'd0, vec_count}, 32'd0);
    chk({nm, "_fail"}, {16'd0, fail_count}, 32'd0);
    chk({nm, "_err"}, {err_input1, err_input2} | {30'd0, err_mode}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    #2 reset_n = 1'b0;
    #2 chk_all_zero("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_start", {30'd0, busy, done}, 32'd0);

    // Run A: healthy DUT, with a start pulse mid-run that must be ignored.
    plan_run(1'b0);
    pulse_start();
    @(negedge clk);
    chk("first_in1", {16'd0, dut_input1}, 32'h0000E270);
    chk("first_in2", {16'd0, dut_input2}, 32'h00007138);
    chk("first_mode", {30'd0, dut_S, dut_I}, 32'd0);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored_start", {31'd0, busy}, 32'd1);
    wait_done("runA");
    repeat (3) @(negedge clk);
    chk("done_held", {31'd0, done}, 32'd1);
    chk("pass_held", {31'd0, pass}, 32'd1);
    chk("vec_held", {16'd0, vec_count}, 32'd8);

    // Run B: start from DONE restarts with cleared counters.
    plan_run(1'b0);
    pulse_start();
    chk("restart_cleared", {14'd0, done, pass, vec_count}, 32'd0);
    @(negedge clk);
    chk("restart_in1", {16'd0, dut_input1}, 32'h0000E270);
    chk("restart_in2", {16'd0, dut_input2}, 32'h00007138);
    wait_done("runB");

    // Run C: sum[0] stuck-at-0.
    fault = 1'b1;
    plan_run(1'b1);
    pulse_start();
    wait_done("runC");
    chk("fault_pass", {31'd0, pass}, 32'd0);
`ifdef ADDSUB_CHECKER_STOP_ON_FAIL_EN
    chk("stop_vec", {16'd0, vec_count}, 32'd4);
    chk("stop_fail", {16'd0, fail_count}, 32'd1);
    chk("stop_held_in1", {16'd0, dut_input1}, 32'h0000ED89);
    chk("stop_held_in2", {16'd0, dut_input2}, 32'h0000C2C4);
`else
    chk("full_vec", {16'd0, vec_count}, 32'd8);
    chk("fail_nonzero", {31'd0, (fail_count != 16'd0)}, 32'd1);
`endif
    fault = 1'b0;

    // Run D: reset asserted mid-SETTLE, no clock edge needed.
    plan_run(1'b0);
    pulse_start();
    @(negedge clk);
    #2 reset_n = 1'b0;
    opq.delete();
    resq.delete();
    #1 chk_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_idle", {14'd0, busy, done, vec_count}, 32'd0);

    chk("opq_drained", 32'(opq.size()), 32'd0);
    chk("resq_drained", 32'(resq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_checker.md
ADDSUB_CHECKER -- requirements
Module: addsub_checker

Interface
REQ-001 Parameter NUM_VECTORS, default 256, shall set the number of vectors applied per run (1..65535).
REQ-002 Parameter SETTLE_CYCLES, default 4, shall set the number of cycles waited after driving operands before sampling (1..255).
REQ-003 Parameter SEED, default 16'hACE1, shall set the nonzero LFSR start value.
REQ-004 clk  input  1  single clock; all logic shall update on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request, sampled high in IDLE or DONE.
REQ-007 dut_input1, dut_input2  output  16 each  registered operands to the adder-subtractor under test.
REQ-008 dut_S, dut_I  output  1 each  registered mode: S=1 signed, I=1 subtract.
REQ-009 dut_sum  input  16; dut_outc, dut_borrow, dut_overflow  input  1 each  DUT results.
REQ-010 busy, done, pass  output  1 each  run status.
REQ-011 vec_count, fail_count  output  16 each  vectors checked, mismatches seen.
REQ-012 err_input1, err_input2  output  16 each; err_mode  output  2  ({S,I}) first failing vector.

Function
REQ-013 FSM states IDLE, DRIVE, SETTLE, CHECK, DONE; busy=1 in DRIVE/SETTLE/CHECK only.
REQ-014 IDLE/DONE + start=1 -> DRIVE; clears vec_count, fail_count, err_*, pass, done; reloads LFSR with SEED.
REQ-015 start while busy shall be ignored.
REQ-016 Operands: 16-bit Galois LFSR, taps 16'hB400 (shift right, XOR taps when shifted-out bit=1); dut_input1 = value after one step, dut_input2 = value after a second step, both in DRIVE (one cycle).
REQ-017 {dut_S,dut_I} shall equal vec_count[1:0] in DRIVE, cycling all four modes.
REQ-018 SETTLE shall last exactly SETTLE_CYCLES cycles with operands held; then CHECK for one cycle.
REQ-019 Golden: I=0 -> {outc,sum}=input1+input2; I=1 -> {outc,sum}=input1+~input2+1 (17-bit).
REQ-020 Golden borrow = I & (input1 < input2 unsigned), compared only when I=1.
REQ-021 Golden overflow = signed overflow of the 16-bit result, compared only when S=1.
REQ-022 CHECK: sum and outc always compared; any mismatch increments fail_count (saturate at 16'hFFFF) and, on first failure only, loads err_*.
REQ-023 CHECK shall increment vec_count; vec_count=NUM_VECTORS -> DONE, else -> DRIVE.
REQ-024 Per-vector latency shall be SETTLE_CYCLES+2 cycles.
REQ-025 DONE: done=1, pass=(fail_count==0), held until next start.

Reset
REQ-026 reset_n low, at any time including mid-run: state IDLE, LFSR=SEED, all outputs 0, effective immediately without clk.
REQ-027 Leaving reset shall not start a run; a start pulse is required.

Configuration
REQ-028 Macro ADDSUB_CHECKER_STOP_ON_FAIL_EN defined: first mismatch in CHECK -> DONE directly (pass=0, vec_count includes failing vector, operands held on dut_* ports).
REQ-029 Macro undefined: run always completes all NUM_VECTORS regardless of failures.

Verification
REQ-030 Reset: assert reset_n=0 mid-SETTLE -> all outputs 0, busy=0 same cycle; release, no start -> stays IDLE.
REQ-031 First vector, SEED default: dut_input1=16'hE270, dut_input2=16'h7138, S=0, I=0; golden DUT -> sum=16'h53A8, outc=1, no failure.
REQ-032 Correct DUT, NUM_VECTORS=8, SETTLE_CYCLES=2 -> done after 32 busy cycles, vec_count=8, fail_count=0, pass=1.
REQ-033 DUT with sum[0] stuck-at-0, macro undefined -> vec_count=NUM_VECTORS, fail_count>0, pass=0, err_* = first vector with golden sum[0]=1.
REQ-034 Same faulty DUT, ADDSUB_CHECKER_STOP_ON_FAIL_EN defined -> done at first failure, fail_count=1, vec_count=index+1.
REQ-035 start pulsed during busy -> ignored, counters unchanged; start in DONE -> new run, counters cleared, first vector again 16'hE270/16'h7138.
